// File: rtl/mutative_cache_pkg.sv
// Shared widths, tag word layout, request opcodes and FSM state encoding
// for the mutative tag controller.
package mutative_cache_pkg;

  localparam int IDX_W = 7;
  localparam int TAG_W = 20;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
  } tag_word_t;

  typedef enum logic [1:0] {
    TAG_LOOKUP = 2'd0,
    TAG_FILL   = 2'd1,
    TAG_INVAL  = 2'd2
  } tag_op_e;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } tag_state_e;

endpackage

// File: rtl/mutative_tag_ctrl_if.sv
// Request/response bundle of the tag controller; dbg_state mirrors the FSM.
interface mutative_tag_ctrl_if #(
  parameter int IDX_W = mutative_cache_pkg::IDX_W,
  parameter int TAG_W = mutative_cache_pkg::TAG_W
);
  // A request transfers on any clock edge where req_valid && req_ready;
  // responses are single-cycle resp_valid pulses and cannot be stalled.
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [IDX_W-1:0] req_index;
  logic [TAG_W-1:0] req_tag;

  logic             resp_valid;
  logic             resp_hit;
  logic [IDX_W-1:0] resp_index;
  logic [TAG_W-1:0] resp_tag;
  logic             resp_vbit;

  mutative_cache_pkg::tag_state_e dbg_state;

  modport master (
    output req_valid, req_op, req_index, req_tag,
    input  req_ready, resp_valid, resp_hit, resp_index, resp_tag, resp_vbit,
    input  dbg_state
  );

  modport slave (
    input  req_valid, req_op, req_index, req_tag,
    output req_ready, resp_valid, resp_hit, resp_index, resp_tag, resp_vbit,
    output dbg_state
  );
endinterface

// File: rtl/mutative_tag_ctrl_cmp.sv
// Combinational tag comparator: hit when the stored word is valid and its
// tag equals the request tag.
module mutative_tag_cmp
  import mutative_cache_pkg::*;
(
  input  tag_word_t        stored,
  input  logic [TAG_W-1:0] req_tag,
  output logic             hit
);
  assign hit = stored.valid && (stored.tag == req_tag);
endmodule

// File: rtl/mutative_tag_ctrl.sv
// Tag-array controller with a two-stage lookup pipeline over a 1-cycle SRAM.
// Define MUTATIVE_TAG_INIT_EN to compile in the power-up invalidation sweep.
module mutative_tag_ctrl #(
  parameter int IDX_W = mutative_cache_pkg::IDX_W,
  parameter int TAG_W = mutative_cache_pkg::TAG_W
) (
  input  logic               clk,
  input  logic               rst,
  mutative_tag_ctrl_if.slave bus,
  output logic               sram_csb,
  output logic               sram_web,
  output logic [IDX_W-1:0]   sram_addr,
  output logic [TAG_W:0]     sram_din,
  input  logic [TAG_W:0]     sram_dout
);
  import mutative_cache_pkg::*;

  tag_state_e       state_q, state_d;
`ifdef MUTATIVE_TAG_INIT_EN
  logic [IDX_W-1:0] sweep_q, sweep_d;
`endif

  logic             s1_valid_q, s1_valid_d;
  logic [IDX_W-1:0] s1_index_q, s1_index_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

  logic             resp_valid_q, resp_valid_d;
  logic             resp_hit_q, resp_hit_d;
  logic [IDX_W-1:0] resp_index_q, resp_index_d;
  logic [TAG_W-1:0] resp_tag_q, resp_tag_d;
  logic             resp_vbit_q, resp_vbit_d;

  logic             is_lookup;
  logic             cmp_hit;
  tag_word_t        stored_w;

  assign stored_w = tag_word_t'(sram_dout);

  mutative_tag_cmp u_cmp (
    .stored  (stored_w),
    .req_tag (s1_tag_q),
    .hit     (cmp_hit)
  );

  // FSM next state and the SRAM port; rst forces the port idle combinationally.
  always_comb begin
    state_d       = state_q;
`ifdef MUTATIVE_TAG_INIT_EN
    sweep_d       = sweep_q;
`endif
    bus.req_ready = 1'b0;
    sram_csb      = 1'b1;
    sram_web      = 1'b1;
    sram_addr     = '0;
    sram_din      = '0;
    is_lookup     = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_INIT: begin
`ifdef MUTATIVE_TAG_INIT_EN
          sram_csb  = 1'b0;
          sram_web  = 1'b0;
          sram_addr = sweep_q;
          sweep_d   = sweep_q + IDX_W'(1);
          if (sweep_q == {IDX_W{1'b1}}) state_d = ST_RUN;
`else
          state_d = ST_RUN;
`endif
        end
        ST_RUN: begin
          bus.req_ready = 1'b1;
          if (bus.req_valid) begin
            sram_csb  = 1'b0;
            sram_addr = bus.req_index;
            case (tag_op_e'(bus.req_op))
              TAG_FILL: begin
                sram_web = 1'b0;
                sram_din = {1'b1, bus.req_tag};
              end
              TAG_INVAL: begin
                sram_web = 1'b0;
                sram_din = {1'b0, bus.req_tag};
              end
              default: is_lookup = 1'b1;
            endcase
          end
        end
        default: state_d = ST_INIT;
      endcase
    end
  end

  // Lookup pipeline: stage 1 waits for sram_dout, stage 2 holds the response.
  always_comb begin
    s1_valid_d   = is_lookup;
    s1_index_d   = bus.req_index;
    s1_tag_d     = bus.req_tag;
    resp_valid_d = s1_valid_q;
    resp_hit_d   = s1_valid_q && cmp_hit;
    resp_index_d = s1_valid_q ? s1_index_q : '0;
    resp_tag_d   = s1_valid_q ? stored_w.tag : '0;
    resp_vbit_d  = s1_valid_q && stored_w.valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_INIT;
`ifdef MUTATIVE_TAG_INIT_EN
      sweep_q      <= '0;
`endif
      s1_valid_q   <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_index_q <= '0;
      resp_tag_q   <= '0;
      resp_vbit_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
`ifdef MUTATIVE_TAG_INIT_EN
      sweep_q      <= sweep_d;
`endif
      s1_valid_q   <= s1_valid_d;
      resp_valid_q <= resp_valid_d;
      resp_hit_q   <= resp_hit_d;
      resp_index_q <= resp_index_d;
      resp_tag_q   <= resp_tag_d;
      resp_vbit_q  <= resp_vbit_d;
    end
    s1_index_q <= s1_index_d;
    s1_tag_q   <= s1_tag_d;
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_hit   = resp_hit_q;
  assign bus.resp_index = resp_index_q;
  assign bus.resp_tag   = resp_tag_q;
  assign bus.resp_vbit  = resp_vbit_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: doc/mutative_tag_ctrl.md
MUTATIVE_TAG_CTRL -- requirements
Module: mutative_tag_ctrl

Interface
REQ-001 Parameters SHALL be, one per line:
 - IDX_W, 7, set-index width (128 sets).
 - TAG_W, 20, stored tag width; SRAM word = TAG_W+1.
REQ-002 Ports SHALL be, one per line:
 - clk  in  1  single clock for the block and the tag SRAM.
 - rst  in  1  synchronous, active-high reset.
 - req_valid  in  1  request present.
 - req_ready  out  1  request accepted when high with req_valid.
 - req_op  in  2  0=LOOKUP, 1=FILL, 2=INVAL, 3=reserved (treated as LOOKUP).
 - req_index  in  IDX_W  set index.
 - req_tag  in  TAG_W  tag to compare or write.
 - resp_valid  out  1  lookup result valid, one-cycle pulse.
 - resp_hit  out  1  stored valid bit set and stored tag == request tag.
 - resp_index  out  IDX_W  index of the responding lookup.
 - resp_tag  out  TAG_W  stored tag read from the array.
 - resp_vbit  out  1  stored valid bit.
 - sram_csb  out  1  tag SRAM chip select, active low.
 - sram_web  out  1  tag SRAM write enable, active low.
 - sram_addr  out  IDX_W  tag SRAM address.
 - sram_din  out  TAG_W+1  tag SRAM write data {valid, tag}.
 - sram_dout  in  TAG_W+1  tag SRAM read data, valid the cycle after the SRAM samples its inputs.

Function
REQ-003 Tag word format SHALL be bit TAG_W = valid and bits TAG_W-1:0 = tag.
REQ-004 The FSM SHALL have two states: INIT (invalidation sweep) and RUN.
REQ-005 INIT SHALL write 0 to index k in cycle k (k = 0..127) with sram_csb=0 and sram_web=0, and SHALL enter RUN after index 127 is written.
REQ-006 req_ready SHALL be 1 only in RUN.
REQ-007 In RUN, an accepted request SHALL drive the SRAM combinationally in its accept cycle N:
 - sram_csb=0, sram_addr=req_index.
 - sram_web=0 for FILL/INVAL, 1 for LOOKUP.
 - sram_din={1,req_tag} for FILL, {0,req_tag} for INVAL.
REQ-008 With no accepted request, sram_csb SHALL be 1.
REQ-009 A LOOKUP accepted in cycle N SHALL be held in a stage-1 register (valid, index, tag) during N+1.
REQ-010 The hit compare SHALL use sram_dout in N+1 and register the result so that resp_valid=1 with all resp_* fields in cycle N+2 (latency 2).
REQ-011 Throughput SHALL be one request per cycle with no backpressure on responses.
REQ-012 FILL and INVAL SHALL produce no response.
REQ-013 A LOOKUP accepted in the cycle immediately after a FILL/INVAL to the same index SHALL observe the new contents.
REQ-014 When resp_valid=0, resp_hit, resp_vbit, resp_tag and resp_index SHALL be 0.

Reset
REQ-015 While rst=1 at a clock edge:
 - stage-1 and response valids SHALL clear (in-flight lookups discarded, no response issued).
 - all resp_* outputs SHALL reset to 0.
 - the sweep counter SHALL reset to 0.
 - the FSM SHALL enter INIT.
REQ-016 During the reset cycle, sram_csb SHALL be 1 and req_ready SHALL be 0.
REQ-017 Reset asserted mid-sweep SHALL restart the sweep at index 0.

Configuration
REQ-018 Macro MUTATIVE_TAG_INIT_EN:
 - Defined: the INIT sweep of REQ-005 SHALL be compiled in.
 - Undefined: the FSM SHALL enter RUN the cycle after reset deasserts, with no SRAM writes, and array contents are undefined until filled.

Structure
REQ-019 A shared package mutative_cache_pkg SHALL hold:
 - IDX_W and TAG_W.
 - the tag word typedef (valid + tag).
 - the req_op enum (TAG_LOOKUP, TAG_FILL, TAG_INVAL).
REQ-020 The block SHALL contain one sub-module, mutative_tag_cmp: a combinational comparator taking the stored word and request tag and producing hit.

Verification
REQ-021 Benches SHALL cover:
 - Reset then idle (macro defined): req_ready=0 for exactly 128 cycles after reset deasserts, with sram_addr sweeping 0..127, then req_ready=1.
 - FILL idx 5 tag 0xABCDE, LOOKUP idx 5 tag 0xABCDE next cycle: resp_valid 2 cycles later, resp_hit=1, resp_tag=0xABCDE, resp_vbit=1.
 - LOOKUP idx 5 tag 0x12345 after the above: resp_hit=0, resp_tag=0xABCDE, resp_vbit=1.
 - INVAL idx 5 then LOOKUP idx 5 tag 0xABCDE: resp_hit=0, resp_vbit=0.
 - Back-to-back LOOKUPs to idx 0..3 in 4 cycles: 4 consecutive resp_valid pulses with resp_index 0..3 in order.
 - rst asserted for one cycle while 2 lookups are in flight and again mid-sweep at index 60: no response pulse occurs and the sweep restarts at address 0.
